// File: rtl/iobus_arbiter_if.sv
// Two-master I/O bus arbiter signal bundle: master request/response side plus peripheral side.
// The arbiter connects through the slave modport and the driving environment through the master modport.
interface iobus_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic        m0_wr;
    logic        m1_wr;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic        m0_gnt;
    logic        m1_gnt;
    logic        m0_done;
    logic        m1_done;
    logic        m0_err;
    logic        m1_err;
    logic [31:0] rdata;
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic        iobus_rd;
    logic [31:0] iobus_in;
    logic        iobus_ack;

    modport slave (
        input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  iobus_in, iobus_ack,
        output m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, rdata,
        output iobus_addr, iobus_out, iobus_wr, iobus_rd
    );

    modport master (
        output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
        output iobus_in, iobus_ack,
        input  m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, rdata,
        input  iobus_addr, iobus_out, iobus_wr, iobus_rd
    );
endinterface

// File: rtl/iobus_arbiter.sv
// Round-robin arbiter granting one of two masters a single I/O bus transaction at a time,
// with a bounded wait for the peripheral acknowledge and a one-cycle done/error pulse.
module iobus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    iobus_arbiter_if.slave  bus
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t        state;
    logic          owner;
    logic          last_owner;
    logic          err_flag;
    logic [CW-1:0] cnt;

    logic          pick;
    logic          sel_wr;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;

    // Contention goes to the master not served last; a lone requester always wins.
    always_comb begin
        pick = 1'b0;
        if (bus.m0_req && bus.m1_req) begin
            pick = ~last_owner;
        end else begin
            pick = bus.m1_req;
        end
        sel_wr    = pick ? bus.m1_wr    : bus.m0_wr;
        sel_addr  = pick ? bus.m1_addr  : bus.m0_addr;
        sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            owner          <= 1'b0;
            last_owner     <= 1'b1;
            err_flag       <= 1'b0;
            cnt            <= '0;
            bus.m0_gnt     <= 1'b0;
            bus.m1_gnt     <= 1'b0;
            bus.m0_done    <= 1'b0;
            bus.m1_done    <= 1'b0;
            bus.m0_err     <= 1'b0;
            bus.m1_err     <= 1'b0;
            bus.rdata      <= '0;
            bus.iobus_addr <= '0;
            bus.iobus_out  <= '0;
            bus.iobus_wr   <= 1'b0;
            bus.iobus_rd   <= 1'b0;
        end else begin
            bus.m0_done <= 1'b0;
            bus.m1_done <= 1'b0;
            bus.m0_err  <= 1'b0;
            bus.m1_err  <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        owner          <= pick;
                        err_flag       <= 1'b0;
                        cnt            <= '0;
                        bus.m0_gnt     <= ~pick;
                        bus.m1_gnt     <= pick;
                        bus.iobus_addr <= sel_addr;
                        bus.iobus_out  <= sel_wdata;
                        bus.iobus_wr   <= sel_wr;
                        bus.iobus_rd   <= ~sel_wr;
                        state          <= ACCESS;
                    end
                end

                ACCESS: begin
                    // An acknowledge on the final allowed cycle still completes cleanly.
                    if (bus.iobus_ack) begin
                        if (bus.iobus_rd) begin
                            bus.rdata <= bus.iobus_in;
                        end
                        bus.m0_gnt   <= 1'b0;
                        bus.m1_gnt   <= 1'b0;
                        bus.iobus_wr <= 1'b0;
                        bus.iobus_rd <= 1'b0;
                        state        <= DONE;
                    end else if (cnt == LAST_CNT) begin
                        bus.rdata    <= '0;
                        err_flag     <= 1'b1;
                        bus.m0_gnt   <= 1'b0;
                        bus.m1_gnt   <= 1'b0;
                        bus.iobus_wr <= 1'b0;
                        bus.iobus_rd <= 1'b0;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    bus.m0_done <= ~owner;
                    bus.m1_done <= owner;
                    bus.m0_err  <= ~owner & err_flag;
                    bus.m1_err  <= owner & err_flag;
                    last_owner  <= owner;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_one_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.m0_gnt && bus.m1_gnt));
    a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.iobus_wr && bus.iobus_rd));
    a_one_done: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.m0_done && bus.m1_done));

endmodule

// File: tb/tb_iobus_arbiter.sv
// Randomized self-checking bench for iobus_arbiter against a transaction-level model
// (round-robin winner, acknowledge latency, timeout and read-data rules).
module tb_iobus_arbiter;
    localparam int unsigned TO = 15;

    logic clk = 1'b0;
    logic rst_n;

    iobus_arbiter_if bus();

    iobus_arbiter #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        last_m1;
    logic [31:0] exp_rdata;

    task automatic check_all_zero(input string name);
        total++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err,
             bus.iobus_wr, bus.iobus_rd, bus.rdata, bus.iobus_addr, bus.iobus_out} !== 104'd0) begin
            bad++;
            $display("FAIL %s: got ctl=%b rdata=%h addr=%h out=%h, need all zero", name,
                     {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err,
                      bus.iobus_wr, bus.iobus_rd}, bus.rdata, bus.iobus_addr, bus.iobus_out);
        end
    endtask

    // One complete transaction; called at a negedge, returns at the negedge of the done pulse.
    // ack_at: ACCESS cycle (1-based) carrying the acknowledge; outside 1..TO means it never comes.
    task automatic do_txn(input logic r0, input logic r1, input logic w0, input logic w1,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input int ack_at, input logic [31:0] in_data, input logic drop_mid);
        logic        win;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        to;
        int          n;
        win = (r0 && r1) ? ~last_m1 : r1;
        w   = win ? w1 : w0;
        a   = win ? a1 : a0;
        d   = win ? d1 : d0;
        to  = !(ack_at >= 1 && ack_at <= int'(TO));
        n   = to ? int'(TO) : ack_at;

        bus.m0_req = r0;  bus.m1_req = r1;
        bus.m0_wr = w0;   bus.m1_wr = w1;
        bus.m0_addr = a0; bus.m1_addr = a1;
        bus.m0_wdata = d0; bus.m1_wdata = d1;
        bus.iobus_ack = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            total++;
            if ({bus.m0_gnt, bus.m1_gnt, bus.iobus_wr, bus.iobus_rd, bus.iobus_addr, bus.iobus_out}
                !== {~win, win, w, ~w, a, d}) begin
                bad++;
                $display("FAIL access_c%0d: got gnt=%b%b wr=%b rd=%b addr=%h out=%h, need gnt=%b%b wr=%b rd=%b addr=%h out=%h",
                         c, bus.m0_gnt, bus.m1_gnt, bus.iobus_wr, bus.iobus_rd, bus.iobus_addr,
                         bus.iobus_out, ~win, win, w, ~w, a, d);
            end
            bus.m0_addr  = $urandom;  bus.m1_addr  = $urandom;
            bus.m0_wdata = $urandom;  bus.m1_wdata = $urandom;
            bus.m0_wr    = 1'($urandom); bus.m1_wr = 1'($urandom);
            if (drop_mid && c == 1) begin
                if (win) bus.m1_req = 1'b0;
                else     bus.m0_req = 1'b0;
            end
            bus.iobus_ack = (c == ack_at);
            bus.iobus_in  = (c == ack_at) ? in_data : $urandom;
        end

        @(negedge clk);
        if (to)      exp_rdata = '0;
        else if (!w) exp_rdata = in_data;
        total++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.iobus_wr, bus.iobus_rd, bus.m0_done, bus.m1_done,
             bus.m0_err, bus.m1_err} !== 8'd0 || bus.rdata !== exp_rdata) begin
            bad++;
            $display("FAIL done_state: got ctl=%b rdata=%h, need ctl=00000000 rdata=%h",
                     {bus.m0_gnt, bus.m1_gnt, bus.iobus_wr, bus.iobus_rd, bus.m0_done,
                      bus.m1_done, bus.m0_err, bus.m1_err}, bus.rdata, exp_rdata);
        end
        bus.iobus_ack = 1'($urandom);
        bus.iobus_in  = $urandom;

        @(negedge clk);
        total++;
        if ({bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err, bus.m0_gnt, bus.m1_gnt,
             bus.iobus_wr, bus.iobus_rd} !== {~win, win, ~win & to, win & to, 4'b0000}
            || bus.rdata !== exp_rdata) begin
            bad++;
            $display("FAIL done_pulse: got done=%b%b err=%b%b gnt=%b%b strb=%b%b rdata=%h, need done=%b%b err=%b%b gnt=00 strb=00 rdata=%h",
                     bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err, bus.m0_gnt, bus.m1_gnt,
                     bus.iobus_wr, bus.iobus_rd, bus.rdata, ~win, win, ~win & to, win & to, exp_rdata);
        end
        last_m1 = win;
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        bus.iobus_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        bus.m0_wr = 1'b0;  bus.m1_wr = 1'b0;
        bus.m0_addr = '0;  bus.m1_addr = '0;
        bus.m0_wdata = '0; bus.m1_wdata = '0;
        bus.iobus_in = '0; bus.iobus_ack = 1'b0;
        last_m1   = 1'b1;
        exp_rdata = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_release_idle");
    endtask

    task automatic test_idle_ack();
        for (int i = 0; i < 3; i++) begin
            bus.iobus_ack = 1'b1;
            bus.iobus_in  = $urandom;
            @(negedge clk);
            total++;
            if ({bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.iobus_wr, bus.iobus_rd} !== 6'd0
                || bus.rdata !== exp_rdata) begin
                bad++;
                $display("FAIL idle_ack: got ctl=%b rdata=%h, need ctl=000000 rdata=%h",
                         {bus.m0_gnt, bus.m1_gnt, bus.m0_done, bus.m1_done, bus.iobus_wr,
                          bus.iobus_rd}, bus.rdata, exp_rdata);
            end
        end
        bus.iobus_ack = 1'b0;
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 4; i++) begin
            do_txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h2000_0000 + i, 32'h3000_0000 + i,
                   $urandom, $urandom, 1 + i, $urandom, 1'b0);
        end
    endtask

    task automatic test_basic_read();
        do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h1100_0000, 32'h0, 32'h0, 32'h0, 1, 32'h0000_0002, 1'b0);
    endtask

    task automatic test_write();
        do_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h1100_0020, 32'h0, 32'hABCD_1234, 4,
               32'hDEAD_BEEF, 1'b0);
    endtask

    task automatic test_timeout();
        do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h1100_0040, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    endtask

    task automatic test_ack_last();
        do_txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h1100_0044, 32'h0, 32'h0, 32'h0, int'(TO),
               32'h5A5A_0F0F, 1'b0);
    endtask

    task automatic test_req_drop();
        do_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1100_0080, 32'h0, 32'h0, 3, 32'h1357_9BDF, 1'b1);
    endtask

    task automatic test_reset_mid();
        bus.m0_req = 1'b1; bus.m0_wr = 1'b0; bus.m0_addr = 32'h1100_00C0;
        bus.m0_wdata = 32'h0; bus.iobus_ack = 1'b0;
        @(posedge clk);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        bus.m0_req = 1'b0;
        #1 check_all_zero("reset_async");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_all_zero("reset_no_done");
        end
        rst_n = 1'b1;
        last_m1   = 1'b1;
        exp_rdata = '0;
        do_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h1100_00D0, 32'h0, 32'h0, 2, 32'h2468_ACE0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            int unsigned rq;
            rq = $urandom_range(3, 1);
            do_txn(rq[0], rq[1], 1'($urandom), 1'($urandom), $urandom, $urandom,
                   $urandom, $urandom, int'($urandom_range(17, 0)), $urandom, 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_idle_ack();
        test_basic_read();
        test_write();
        test_timeout();
        test_ack_last();
        test_req_drop();
        test_reset_mid();
        test_random();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iobus_arbiter.md
IOBUS_ARBITER -- requirements
Module: iobus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles in ACCESS waiting for IOBUS_ACK before abort.
REQ-002 CLK  in  1  single clock; all state updates on rising edge.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 M0_REQ, M1_REQ  in  1  per-master transaction request, held until matching DONE.
REQ-005 M0_WR, M1_WR  in  1  per-master: 1 = write, 0 = read.
REQ-006 M0_ADDR, M1_ADDR  in  32  per-master address.
REQ-007 M0_WDATA, M1_WDATA  in  32  per-master write data.
REQ-008 M0_GNT, M1_GNT  out  1  high while that master owns the bus.
REQ-009 M0_DONE, M1_DONE  out  1  one-cycle completion pulse.
REQ-010 M0_ERR, M1_ERR  out  1  one-cycle pulse coincident with DONE on timeout.
REQ-011 RDATA  out  32  read data for the master receiving DONE.
REQ-012 IOBUS_ADDR  out  32  bus address; IOBUS_OUT  out  32  bus write data.
REQ-013 IOBUS_WR  out  1  write strobe; IOBUS_RD  out  1  read strobe.
REQ-014 IOBUS_IN  in  32  peripheral read data; IOBUS_ACK  in  1  peripheral completion.

Function
REQ-015 FSM states IDLE, ACCESS, DONE; all outputs registered.
REQ-016 IDLE: no REQ -> stay; any REQ at edge k -> latch winner's WR/ADDR/WDATA, assert winner GNT and IOBUS_WR (WR=1) or IOBUS_RD (WR=0) from cycle k+1, enter ACCESS.
REQ-017 Arbitration round-robin: single REQ wins; both REQ -> master not granted last wins; pointer after reset favours M0.
REQ-018 ACCESS: IOBUS_ADDR/IOBUS_OUT/strobe/GNT held stable from latched values; changes on M*_ADDR/WDATA/WR ignored.
REQ-019 ACCESS with IOBUS_ACK=1 at edge -> capture IOBUS_IN into RDATA (reads only; writes leave RDATA unchanged), drop strobe and GNT, enter DONE.
REQ-020 Timeout counter clears on ACCESS entry, increments each ACCESS cycle without ACK; ACK absent on TIMEOUT-th ACCESS cycle -> RDATA = 0, drop strobe and GNT, enter DONE with error flag set.
REQ-021 ACK and timeout on same edge -> ACK wins, no error.
REQ-022 DONE: pulse owner's DONE (and ERR if flagged) for exactly one cycle, update round-robin pointer to owner, return to IDLE.
REQ-023 Minimum transaction: request edge to DONE pulse = 3 cycles (ACK on first ACCESS cycle); one IDLE cycle always separates transactions.
REQ-024 REQ deassertion during ACCESS does not abort; transaction completes and DONE pulses.
REQ-025 Never more than one GNT, one strobe, one DONE high; IOBUS_WR and IOBUS_RD never both high.
REQ-026 IOBUS_ACK outside ACCESS ignored.

Reset
REQ-027 RST_N low -> immediately: state IDLE, all GNT/DONE/ERR/IOBUS_WR/IOBUS_RD = 0, RDATA/IOBUS_ADDR/IOBUS_OUT = 0, counter 0, pointer favours M0.
REQ-028 Reset mid-ACCESS abandons transaction with no DONE pulse; first post-reset request re-arbitrated normally.

Verification
REQ-029 M0 read 0x11000000, ACK on first ACCESS cycle with IOBUS_IN=0x00000002 -> IOBUS_RD one cycle, M0_DONE at cycle 3, RDATA=0x00000002, M0_ERR=0.
REQ-030 M0 and M1 request same edge, both held -> grants M0, M1, M0, M1 alternating; one IDLE cycle between.
REQ-031 M1 write 0x11000020 data 0xABCD1234, ACK after 4 cycles -> IOBUS_WR held 4 cycles with stable addr/data, M1_DONE once, RDATA unchanged.
REQ-032 M0 read, ACK never -> strobe drops after 15 ACCESS cycles, M0_DONE and M0_ERR pulse together, RDATA=0.
REQ-033 ACK on exactly the 15th ACCESS cycle -> DONE without ERR, RDATA=IOBUS_IN.
REQ-034 RST_N low during ACCESS -> all outputs 0 asynchronously, no DONE; after release, M1 request alone granted next.
